// File: rtl/frame_stats_packer.sv
// Packs groups of 4 accepted 4-bit samples into a sum/max/min result with a valid/ready output.
// Define FRAME_STATS_PACKER_AVG_EN to add the registered out_avg (floor of sum/4) output.
module frame_stats_packer (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    input  logic       clear,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_sum,
    output logic [3:0] out_max,
    output logic [3:0] out_min
`ifdef FRAME_STATS_PACKER_AVG_EN
    ,
    output logic [3:0] out_avg
`endif
);

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [5:0] acc_sum_q, acc_sum_d;
    logic [3:0] acc_max_q, acc_max_d;
    logic [3:0] acc_min_q, acc_min_d;
    logic       out_valid_q, out_valid_d;
    logic [5:0] out_sum_q, out_sum_d;
    logic [3:0] out_max_q, out_max_d;
    logic [3:0] out_min_q, out_min_d;

    logic       accept;
    logic       last_sample;
    logic       result_free;
    logic       handshake;
    logic [5:0] next_sum;
    logic [3:0] next_max;
    logic [3:0] next_min;

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_max   = out_max_q;
    assign out_min   = out_min_q;

    // Accumulator candidate values if the presented sample is taken this edge.
    always_comb begin
        accept      = in_valid && in_ready && !clear;
        last_sample = accept && (cnt_q == 2'd3);
        handshake   = out_valid_q && out_ready;
        result_free = !out_valid_q || out_ready;
        next_sum    = {2'b00, in_data};
        next_max    = in_data;
        next_min    = in_data;
        if (cnt_q != 2'd0) begin
            next_sum = acc_sum_q + {2'b00, in_data};
            next_max = (in_data > acc_max_q) ? in_data : acc_max_q;
            next_min = (in_data < acc_min_q) ? in_data : acc_min_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_sum_d   = acc_sum_q;
        acc_max_d   = acc_max_q;
        acc_min_d   = acc_min_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_max_d   = out_max_q;
        out_min_d   = out_min_q;

        if (clear) begin
            state_d     = COLLECT;
            cnt_d       = 2'd0;
            out_valid_d = 1'b0;
        end else if (state_q == STALL) begin
            // A completed frame waits in the accumulator until the held result drains.
            if (handshake) begin
                out_sum_d   = acc_sum_q;
                out_max_d   = acc_max_q;
                out_min_d   = acc_min_q;
                out_valid_d = 1'b1;
                cnt_d       = 2'd0;
                state_d     = COLLECT;
            end
        end else begin
            if (accept) begin
                acc_sum_d = next_sum;
                acc_max_d = next_max;
                acc_min_d = next_min;
                cnt_d     = cnt_q + 2'd1;
            end
            if (last_sample) begin
                cnt_d = 2'd0;
                if (result_free) begin
                    out_sum_d   = next_sum;
                    out_max_d   = next_max;
                    out_min_d   = next_min;
                    out_valid_d = 1'b1;
                end else begin
                    state_d = STALL;
                end
            end else if (handshake) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= COLLECT;
            cnt_q       <= 2'd0;
            acc_sum_q   <= 6'd0;
            acc_max_q   <= 4'd0;
            acc_min_q   <= 4'd0;
            out_valid_q <= 1'b0;
            out_sum_q   <= 6'd0;
            out_max_q   <= 4'd0;
            out_min_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_sum_q   <= acc_sum_d;
            acc_max_q   <= acc_max_d;
            acc_min_q   <= acc_min_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_max_q   <= out_max_d;
            out_min_q   <= out_min_d;
        end
    end

`ifdef FRAME_STATS_PACKER_AVG_EN
    logic [3:0] out_avg_q, out_avg_d;

    assign out_avg_d = out_sum_d[5:2];
    assign out_avg   = out_avg_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_avg_q <= 4'd0;
        end else begin
            out_avg_q <= out_avg_d;
        end
    end
`endif

endmodule
